multibyte_add_sequencer: RTL

Sequences a wide addition (NBYTES × 8 bits) through a single 8-bit parallel-carry adder, one byte per clock, least-significant byte first, chaining the carry through a register. It sits directly around the 8-bit adder. It accepts operand pairs over a valid/ready handshake, drives the adder's `enable` only while a byte is being processed, and presents the assembled result with carry-out and signed overflow over a second valid/ready handshake.

---
 rtl/add_seq_pkg.sv | 16 +
 rtl/parallel_carry_adder_8bit_with_enable.sv | 47 ++++
 rtl/multibyte_add_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and constants for the multibyte add sequencer
//
// Contents:
//   add_seq_state_t        - sequencer FSM state (IDLE, RUN, DONE)
//   ADD_SEQ_NBYTES_DEFAULT - default operand width in bytes
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    localparam int ADD_SEQ_NBYTES_DEFAULT = 4;

endpackage

// File: rtl/parallel_carry_adder_8bit_with_enable.sv
// rtl/parallel_carry_adder_8bit_with_enable.sv - 8-bit carry-lookahead adder with enable gating
//
// Ports:
//   a, b   in  8 : addends
//   cin    in  1 : carry in
//   enable in  1 : when low, sum and cout are forced to 0
//   sum    out 8 : a + b + cin (low 8 bits)
//   cout   out 1 : carry out of bit 7
module parallel_carry_adder_8bit_with_enable (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       enable,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Each carry is built as a flat sum of generate terms qualified by the
    // propagate chain below them, so no carry depends on another carry.
    always_comb begin
        logic cc;
        logic pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        cc   = 1'b0;
        pp   = 1'b1;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            cc = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = enable ? (p ^ c[7:0]) : 8'h00;
    assign cout = enable ? c[8] : 1'b0;

endmodule

// File: rtl/multibyte_add_sequencer.sv
// rtl/multibyte_add_sequencer.sv - wide addition sequenced byte-serially through one 8-bit adder
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (op_a, op_b, cin sampled on accept)
//   out_valid/out_ready : result handshake (result, cout, ovf held until taken)
//   busy                : high while an operation is in RUN or DONE
module multibyte_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int NBYTES = ADD_SEQ_NBYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    add_seq_state_t  state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic [IDXW-1:0] idx;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic            add_en;
    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic            add_cin;
    logic [7:0]      add_sum;
    logic            add_cout;

    // Adder inputs are held at zero outside RUN so it sees no toggling.
    always_comb begin
        add_en  = (state == RUN);
        add_a   = add_en ? a_sh[7:0] : 8'h00;
        add_b   = add_en ? b_sh[7:0] : 8'h00;
        add_cin = add_en ? carry_q : 1'b0;
    end

    parallel_carry_adder_8bit_with_enable u_adder (
        .a      (add_a),
        .b      (add_b),
        .cin    (add_cin),
        .enable (add_en),
        .sum    (add_sum),
        .cout   (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh       <= op_a;
                        b_sh       <= op_b;
                        carry_q    <= cin;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    result_q[idx*8 +: 8] <= add_sum;
                    carry_q              <= add_cout;
                    a_sh                 <= a_sh >> 8;
                    b_sh                 <= b_sh >> 8;
                    if (idx == LAST_IDX) begin
                        // Low byte of the shifters now holds the operand MSBs.
                        cout_q      <= add_cout;
                        ovf_q       <= (a_sh[7] == b_sh[7]) && (add_sum[7] != a_sh[7]);
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
